// File: rtl/turn_scheduler_pkg.sv
//----------------------------------------------------------------------------
// Module  : turn_scheduler_pkg
// Brief   : Shared state encoding and text/key codes for the battle turn path.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package turn_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ORDER = 3'd1,
    ST_CALC  = 3'd2,
    ST_APPLY = 3'd3,
    ST_TEXT  = 3'd4,
    ST_FIN   = 3'd5
  } ts_state_e;

  localparam logic [1:0] TXT_NONE   = 2'd0;
  localparam logic [1:0] TXT_PLAYER = 2'd1;
  localparam logic [1:0] TXT_ENEMY  = 2'd2;
  localparam logic [1:0] TXT_MISS   = 2'd3;

  // USB HID usage code for the Enter key
  localparam logic [7:0] KEY_ENTER  = 8'h28;

endpackage

`default_nettype wire

// File: rtl/turn_scheduler_if.sv
//----------------------------------------------------------------------------
// Module  : turn_scheduler_if
// Brief   : Bundle between the battle FSM / datapath and the turn scheduler.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface turn_scheduler_if #(
  parameter int HP_W = 8
);
  logic            start;
  logic [HP_W-1:0] player_speed;
  logic [HP_W-1:0] enemy_speed;
  logic [HP_W-1:0] player_acc;
  logic [HP_W-1:0] enemy_acc;
  logic [HP_W-1:0] rnd;
  logic [HP_W-1:0] damage;
  logic [HP_W-1:0] player_hp;
  logic [HP_W-1:0] enemy_hp;
  logic            key_enter;
  logic            is_player;
  logic            hp_we;
  logic            hp_target;
  logic [HP_W-1:0] hp_wdata;
  logic [1:0]      text_sel;
  logic            busy;
  logic            done;
  logic [1:0]      fainted;

  modport master (
    output start, player_speed, enemy_speed, player_acc, enemy_acc, rnd,
           damage, player_hp, enemy_hp, key_enter,
    input  is_player, hp_we, hp_target, hp_wdata, text_sel, busy, done, fainted
  );

  modport slave (
    input  start, player_speed, enemy_speed, player_acc, enemy_acc, rnd,
           damage, player_hp, enemy_hp, key_enter,
    output is_player, hp_we, hp_target, hp_wdata, text_sel, busy, done, fainted
  );
endinterface

`default_nettype wire

// File: rtl/turn_scheduler_key_edge.sv
//----------------------------------------------------------------------------
// Module  : key_edge
// Brief   : Registers a key level and flags its rising edge.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module key_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic rise_o
);
  logic key_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) key_q <= 1'b0;
    else       key_q <= key_i;
  end

  assign rise_o = key_i & ~key_q;
endmodule

`default_nettype wire

// File: rtl/turn_scheduler.sv
//----------------------------------------------------------------------------
// Module  : turn_scheduler
// Brief   : Orders both attacks of a turn, applies damage and waits for ENTER.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module turn_scheduler
  import turn_scheduler_pkg::*;
#(
  parameter int HP_W     = 8,
  parameter int CALC_LAT = 1,
  parameter int PCT      = 100
) (
  input  logic            Clk,
  input  logic            Reset,
  turn_scheduler_if.slave bus_io
);
  localparam int            CW     = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CALC_LAT - 1);

  ts_state_e     state_q, state_d;
  logic          attacker_q, attacker_d;   // 1 = player attacks
  logic          slot_q, slot_d;
  logic          hit_q, hit_d;
  logic          ko_q, ko_d;
  logic          is_player_q, is_player_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic            w_rise;
  logic [HP_W-1:0] w_def_hp;
  logic [HP_W-1:0] w_new_hp;
  logic [HP_W-1:0] w_acc;
  logic [31:0]     w_roll;
  logic            w_hit_new;
  logic            w_hp_we;
  logic            w_hp_target;
  logic [HP_W-1:0] w_hp_wdata;
  logic [1:0]      w_text_sel;
  logic            w_done;
  logic [1:0]      w_fainted;

  key_edge u_key_edge (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .key_i  (bus_io.key_enter),
    .rise_o (w_rise)
  );

  assign w_def_hp = attacker_q ? bus_io.enemy_hp : bus_io.player_hp;
  assign w_new_hp = (bus_io.damage >= w_def_hp) ? '0 : w_def_hp - bus_io.damage;
  assign w_roll   = 32'(bus_io.rnd) % 32'(PCT) + 32'd1;

  always_comb begin
    state_d     = state_q;
    attacker_d  = attacker_q;
    slot_d      = slot_q;
    hit_d       = hit_q;
    ko_d        = ko_q;
    is_player_d = is_player_q;
    cnt_d       = cnt_q;
    w_hp_we     = 1'b0;
    w_hp_target = 1'b0;
    w_hp_wdata  = '0;
    w_text_sel  = TXT_NONE;
    w_done      = 1'b0;
    w_fainted   = 2'b00;

    case (state_q)
      ST_IDLE: if (bus_io.start) state_d = ST_ORDER;
      ST_ORDER: begin
        slot_d = 1'b0;
        if (bus_io.player_speed > bus_io.enemy_speed)      attacker_d = 1'b1;
        else if (bus_io.player_speed < bus_io.enemy_speed) attacker_d = 1'b0;
        else                                               attacker_d = bus_io.rnd[0];
        state_d = ST_CALC;
      end
      ST_CALC: begin
        if (cnt_q == C_LAST) state_d = ST_APPLY;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      ST_APPLY: begin
        // the defender index equals the attacker flag: player hits enemy (1)
        if (hit_q) begin
          w_hp_we     = 1'b1;
          w_hp_target = attacker_q;
          w_hp_wdata  = w_new_hp;
        end
        ko_d    = hit_q && (w_new_hp == '0);
        state_d = ST_TEXT;
      end
      ST_TEXT: begin
        w_text_sel = !hit_q ? TXT_MISS : (attacker_q ? TXT_PLAYER : TXT_ENEMY);
        if (w_rise) begin
          if (slot_q || ko_q) begin
            state_d = ST_FIN;
          end else begin
            slot_d     = 1'b1;
            attacker_d = ~attacker_q;
            state_d    = ST_CALC;
          end
        end
      end
      ST_FIN: begin
        w_done    = 1'b1;
        w_fainted = {bus_io.enemy_hp == '0, bus_io.player_hp == '0};
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // accuracy roll uses the rnd value present on the edge that enters CALC
    w_acc     = attacker_d ? bus_io.player_acc : bus_io.enemy_acc;
    w_hit_new = (w_roll <= 32'(w_acc)) || (32'(w_acc) >= 32'(PCT));
    if (state_d == ST_CALC && state_q != ST_CALC) begin
      hit_d       = w_hit_new;
      is_player_d = attacker_d;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      attacker_q  <= 1'b0;
      slot_q      <= 1'b0;
      hit_q       <= 1'b0;
      ko_q        <= 1'b0;
      is_player_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      attacker_q  <= attacker_d;
      slot_q      <= slot_d;
      hit_q       <= hit_d;
      ko_q        <= ko_d;
      is_player_q <= is_player_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus_io.is_player = is_player_q;
  assign bus_io.hp_we     = w_hp_we;
  assign bus_io.hp_target = w_hp_target;
  assign bus_io.hp_wdata  = w_hp_wdata;
  assign bus_io.text_sel  = w_text_sel;
  assign bus_io.busy      = (state_q != ST_IDLE);
  assign bus_io.done      = w_done;
  assign bus_io.fainted   = w_fainted;
endmodule

`default_nettype wire

// File: tb/tb_turn_scheduler.sv
//----------------------------------------------------------------------------
// Module  : tb_turn_scheduler
// Brief   : Directed and randomized turns against a turn-level reference model.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_turn_scheduler;
  import turn_scheduler_pkg::*;

  localparam int HP_W     = 8;
  localparam int CALC_LAT = 1;
  localparam int PCT      = 100;
  localparam int TMO      = 40;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  turn_scheduler_if #(.HP_W(HP_W)) bus ();

  turn_scheduler #(.HP_W(HP_W), .CALC_LAT(CALC_LAT), .PCT(PCT)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .bus_io (bus)
  );

  // HP registers and damage calculator stand-ins
  logic [HP_W-1:0] php, ehp, pdmg, edmg;
  always @(posedge Clk) begin
    if (bus.hp_we) begin
      if (bus.hp_target) ehp <= bus.hp_wdata;
      else               php <= bus.hp_wdata;
    end
  end
  assign bus.player_hp = php;
  assign bus.enemy_hp  = ehp;
  assign bus.damage    = bus.is_player ? pdmg : edmg;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_enter();
    bus.key_enter = 1'b1;
    @(negedge Clk);
    bus.key_enter = 1'b0;
  endtask

  // Runs one full turn and checks every write, text code and the final result.
  task automatic run_turn(input logic [7:0] ps, es, pa, ea, pd, ed, ph, eh, rn,
                          input bit hold_key, input string nm);
    bit first, att, hit;
    int mp, me, hp, nhp, acc, dmg, n, cyc, we_cnt, we_cyc;
    bit exp_hit[2];
    int exp_tgt[2], exp_dat[2], exp_sel[2];
    logic obs_tgt;
    logic [HP_W-1:0] obs_dat;

    // reference: resolve the whole turn from the rules
    first = (ps > es) || (ps == es && rn[0]);
    mp = ph; me = eh; n = 0;
    for (int i = 0; i < 2; i++) begin
      att = (i == 0) ? first : !first;
      acc = att ? int'(pa) : int'(ea);
      dmg = att ? int'(pd) : int'(ed);
      hit = ((int'(rn) % PCT) + 1 <= acc) || (acc >= PCT);
      nhp = 1;
      exp_hit[i] = hit;
      exp_tgt[i] = att ? 1 : 0;
      exp_sel[i] = !hit ? 3 : (att ? 1 : 2);
      if (hit) begin
        hp  = att ? me : mp;
        nhp = (dmg >= hp) ? 0 : hp - dmg;
        if (att) me = nhp; else mp = nhp;
      end
      exp_dat[i] = nhp;
      n++;
      if (hit && nhp == 0) break;
    end

    bus.player_speed = ps; bus.enemy_speed = es;
    bus.player_acc = pa;   bus.enemy_acc = ea;
    pdmg = pd; edmg = ed; php = ph; ehp = eh; bus.rnd = rn;
    bus.start = 1'b1;
    @(negedge Clk);
    bus.start = 1'b0;
    chk({nm, "_busy_rise"}, bus.busy, 1'b1);

    for (int i = 0; i < n; i++) begin
      cyc = 0; we_cnt = 0; we_cyc = -1; obs_tgt = 1'b0; obs_dat = '0;
      while (bus.text_sel == TXT_NONE && cyc < TMO) begin
        if (bus.hp_we) begin
          we_cnt++; we_cyc = cyc; obs_tgt = bus.hp_target; obs_dat = bus.hp_wdata;
          if (hold_key) bus.key_enter = 1'b1;
        end
        @(negedge Clk);
        cyc++;
      end
      chk({nm, "_text_timeout"}, cyc >= TMO, 1'b0);
      chk({nm, "_we_count"}, we_cnt, exp_hit[i] ? 1 : 0);
      if (exp_hit[i]) begin
        chk({nm, "_tgt"}, obs_tgt, exp_tgt[i]);
        chk({nm, "_data"}, obs_dat, exp_dat[i]);
        if (i == 0) chk({nm, "_latency"}, we_cyc, 1 + CALC_LAT);
      end
      chk({nm, "_sel"}, bus.text_sel, exp_sel[i]);
      if (hold_key && bus.key_enter) begin
        repeat (3) @(negedge Clk);
        chk({nm, "_held_key_no_advance"}, bus.text_sel, exp_sel[i]);
        bus.key_enter = 1'b0;
        @(negedge Clk);
      end
      // a start pulse during the turn must be ignored
      bus.start = 1'b1;
      @(negedge Clk);
      bus.start = 1'b0;
      chk({nm, "_sel_hold"}, bus.text_sel, exp_sel[i]);
      press_enter();
    end

    chk({nm, "_done"}, bus.done, 1'b1);
    chk({nm, "_fainted"}, bus.fainted, {me == 0, mp == 0});
    chk({nm, "_busy_in_fin"}, bus.busy, 1'b1);
    chk({nm, "_hp_state"}, {php, ehp}, {8'(mp), 8'(me)});
    @(negedge Clk);
    chk({nm, "_busy_fall"}, {bus.busy, bus.done}, 2'b00);
    @(negedge Clk);
    chk({nm, "_stays_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [7:0] ps, es;
    Reset = 1'b1;
    bus.start = 1'b0; bus.key_enter = 1'b0; bus.rnd = '0;
    bus.player_speed = '0; bus.enemy_speed = '0;
    bus.player_acc = '0; bus.enemy_acc = '0;
    php = 8'd100; ehp = 8'd100; pdmg = '0; edmg = '0;
    repeat (3) @(negedge Clk);
    chk("reset_outputs",
        {bus.is_player, bus.hp_we, bus.hp_target, bus.hp_wdata, bus.text_sel,
         bus.busy, bus.done, bus.fainted}, '0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("idle_after_reset", {bus.busy, bus.done, bus.text_sel}, '0);

    run_turn(8'd50, 8'd30, 8'd100, 8'd100, 8'd20, 8'd20, 8'd100, 8'd100, 8'h00, 0, "basic");
    run_turn(8'd10, 8'd90, 8'd100, 8'd100, 8'd20, 8'd200, 8'd40, 8'd100, 8'h00, 0, "ko");
    run_turn(8'd60, 8'd60, 8'd100, 8'd100, 8'd7, 8'd9, 8'd100, 8'd100, 8'h02, 0, "tie_enemy");
    run_turn(8'd60, 8'd60, 8'd100, 8'd100, 8'd7, 8'd9, 8'd100, 8'd100, 8'h03, 0, "tie_player");
    run_turn(8'd50, 8'd30, 8'd0, 8'd100, 8'd20, 8'd15, 8'd100, 8'd100, 8'h00, 0, "miss");
    run_turn(8'd50, 8'd30, 8'd100, 8'd100, 8'd0, 8'd5, 8'd100, 8'd0, 8'h10, 0, "zero_dmg");
    run_turn(8'd50, 8'd30, 8'd100, 8'd100, 8'd20, 8'd20, 8'd100, 8'd100, 8'h00, 1, "held_key");

    // reset while the second attacker (player) is in CALC
    bus.player_speed = 8'd10; bus.enemy_speed = 8'd90;
    bus.player_acc = 8'd100;  bus.enemy_acc = 8'd100;
    pdmg = 8'd5; edmg = 8'd5; php = 8'd100; ehp = 8'd100; bus.rnd = 8'h00;
    bus.start = 1'b1;
    @(negedge Clk);
    bus.start = 1'b0;
    cnt = 0;
    while (bus.text_sel == TXT_NONE && cnt < TMO) begin
      @(negedge Clk);
      cnt++;
    end
    chk("rst_text_timeout", cnt >= TMO, 1'b0);
    press_enter();
    chk("rst_slot1_player_calc", bus.is_player, 1'b1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_mid_outputs",
        {bus.is_player, bus.hp_we, bus.hp_target, bus.hp_wdata, bus.text_sel,
         bus.busy, bus.done, bus.fainted}, '0);
    Reset = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge Clk);
      if (bus.hp_we || bus.busy) cnt++;
    end
    chk("rst_no_activity", cnt, 0);

    for (int t = 0; t < 40; t++) begin
      ps = 8'($urandom_range(0, 255));
      es = (t % 4 == 0) ? ps : 8'($urandom_range(0, 255));
      run_turn(ps, es, 8'($urandom_range(0, 120)), 8'($urandom_range(0, 120)),
               8'($urandom_range(0, 120)), 8'($urandom_range(0, 120)),
               8'($urandom_range(0, 200)), 8'($urandom_range(0, 200)),
               8'($urandom), 0, $sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
